// File: rtl/dcache_req_responder.sv
// In-order request queue between the pre-MEM data request interface and a
// single-outstanding memory backend port. Optional macro: DCACHE_RESP_ERR_EN.
module dcache_req_responder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dcache_req,
  input  logic        dcache_wr,
  input  logic [1:0]  dcache_size,
  input  logic [3:0]  dcache_wstrb,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_wdata,
  output logic        dcache_addr_ok,
  output logic        dcache_data_ok,
  output logic [31:0] dcache_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
`ifdef DCACHE_RESP_ERR_EN
  input  logic        mem_err,
  output logic        dcache_data_err,
`endif
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  logic              ent_wr_q    [DEPTH];
  logic [1:0]        ent_size_q  [DEPTH];
  logic [3:0]        ent_wstrb_q [DEPTH];
  logic [31:0]       ent_addr_q  [DEPTH];
  logic [31:0]       ent_wdata_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              data_ok_q, data_ok_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              accept;
  logic              pop;
  logic              rsp_err;

  assign dcache_addr_ok = (count_q != FULL_CNT);
  assign accept         = dcache_req && dcache_addr_ok;
  assign pop            = (state_q == RESP);

`ifdef DCACHE_RESP_ERR_EN
  logic err_q, err_d;
  assign rsp_err         = mem_err;
  assign dcache_data_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Queue payload carries no reset; only pointers/count qualify it.
  always_ff @(posedge clk) begin
    if (accept) begin
      ent_wr_q[wr_ptr_q]    <= dcache_wr;
      ent_size_q[wr_ptr_q]  <= (dcache_size == 2'd3) ? 2'd2 : dcache_size;
      ent_wstrb_q[wr_ptr_q] <= dcache_wstrb;
      ent_addr_q[wr_ptr_q]  <= dcache_addr;
      ent_wdata_q[wr_ptr_q] <= dcache_wdata;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    state_d   = state_q;
    mem_req_d = mem_req_q;
    data_ok_d = 1'b0;
    rdata_d   = rdata_q;
`ifdef DCACHE_RESP_ERR_EN
    err_d     = err_q;
`endif
    if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d   = ISSUE;
          mem_req_d = 1'b1;
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d   = RESP;
          data_ok_d = 1'b1;
          rdata_d   = (ent_wr_q[rd_ptr_q] || rsp_err) ? 32'h0 : mem_rdata;
`ifdef DCACHE_RESP_ERR_EN
          err_d     = mem_err;
`endif
        end
      end
      RESP: begin
        // count_d already reflects this pop and any same-cycle accept.
        if (count_d != '0) begin
          state_d   = ISSUE;
          mem_req_d = 1'b1;
        end else begin
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
`ifdef DCACHE_RESP_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
`ifdef DCACHE_RESP_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  // Backend fields come straight from the head entry, which cannot change
  // while a request is pending; they read as zero when no request is up.
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_req_q & ent_wr_q[rd_ptr_q];
  assign mem_size  = mem_req_q ? ent_size_q[rd_ptr_q]  : 2'd0;
  assign mem_wstrb = mem_req_q ? ent_wstrb_q[rd_ptr_q] : 4'd0;
  assign mem_addr  = mem_req_q ? ent_addr_q[rd_ptr_q]  : 32'h0;
  assign mem_wdata = mem_req_q ? ent_wdata_q[rd_ptr_q] : 32'h0;

  assign dcache_data_ok = data_ok_q;
  assign dcache_rdata   = rdata_q;

endmodule

// File: tb/tb_dcache_req_responder.sv
// Directed bench for dcache_req_responder: cycle vectors plus multi-cycle
// sequences for fill, backpressure, ordering, reset and the error option.
module tb_dcache_req_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        dcache_req, dcache_wr;
  logic [1:0]  dcache_size;
  logic [3:0]  dcache_wstrb;
  logic [31:0] dcache_addr, dcache_wdata;
  logic        dcache_addr_ok, dcache_data_ok;
  logic [31:0] dcache_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef DCACHE_RESP_ERR_EN
  logic        mem_err;
  logic        dcache_data_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] got_q [$];
  logic [31:0] mem_model [logic [31:0]];

  always #5 clk = ~clk;

  dcache_req_responder #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .dcache_req(dcache_req), .dcache_wr(dcache_wr), .dcache_size(dcache_size),
    .dcache_wstrb(dcache_wstrb), .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_addr_ok(dcache_addr_ok), .dcache_data_ok(dcache_data_ok), .dcache_rdata(dcache_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
`ifdef DCACHE_RESP_ERR_EN
    .mem_err(mem_err), .dcache_data_err(dcache_data_err),
`endif
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic req, wr; logic [1:0] size; logic [3:0] wstrb; logic [31:0] addr, wdata;
    logic gnt, rvalid; logic [31:0] rdata;
    logic e_addr_ok, e_data_ok; logic [31:0] e_rdata;
    logic e_mem_req, e_mem_wr; logic [1:0] e_mem_size; logic [3:0] e_mem_wstrb;
    logic [31:0] e_mem_addr, e_mem_wdata;
  } vec_t;

  function automatic vec_t mk(
    input logic req, wr, input logic [1:0] size, input logic [3:0] wstrb,
    input logic [31:0] addr, wdata, input logic gnt, rvalid, input logic [31:0] rdata,
    input logic e_aok, e_dok, input logic [31:0] e_rd,
    input logic e_mreq, e_mwr, input logic [1:0] e_msz, input logic [3:0] e_mstb,
    input logic [31:0] e_maddr, e_mwd);
    vec_t v;
    v.req = req; v.wr = wr; v.size = size; v.wstrb = wstrb; v.addr = addr; v.wdata = wdata;
    v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata;
    v.e_addr_ok = e_aok; v.e_data_ok = e_dok; v.e_rdata = e_rd;
    v.e_mem_req = e_mreq; v.e_mem_wr = e_mwr; v.e_mem_size = e_msz; v.e_mem_wstrb = e_mstb;
    v.e_mem_addr = e_maddr; v.e_mem_wdata = e_mwd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {16'hBEEF, a[15:0]};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] old;
    old = model_read(a);
    for (int b = 0; b < 4; b++)
      if (s[b]) old[8*b +: 8] = d[8*b +: 8];
    mem_model[a] = old;
  endtask

  task automatic push(input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    @(negedge clk);
    dcache_req = 1'b1; dcache_wr = wr; dcache_size = size;
    dcache_wstrb = wstrb; dcache_addr = addr; dcache_wdata = wdata;
    #1;
    while (!dcache_addr_ok && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!dcache_addr_ok) chk("push_timeout", 32'(dcache_addr_ok), 32'd1);
    @(posedge clk); #1;
    dcache_req = 1'b0;
  endtask

  // Backend model: grants whenever asked, answers one cycle after the grant.
  task automatic serve(input int n, input int budget);
    int seen;
    int cyc;
    logic pend;
    logic [31:0] pend_data;
    seen = 0; cyc = 0; pend = 1'b0; pend_data = '0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      mem_gnt = mem_req;
      mem_rvalid = pend;
      mem_rdata = pend_data;
`ifdef DCACHE_RESP_ERR_EN
      mem_err = 1'b0;
`endif
      #1;
      if (dcache_data_ok) begin
        got_q.push_back(dcache_rdata);
        seen++;
      end
      if (mem_req && mem_gnt) begin
        if (mem_wr) begin
          model_write(mem_addr, mem_wdata, mem_wstrb);
          pend_data = 32'h5A5A5A5A;
        end else begin
          pend_data = model_read(mem_addr);
        end
        pend = 1'b1;
      end else begin
        pend = 1'b0;
      end
      cyc++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("serve_count", 32'(seen), 32'(n));
  endtask

  task automatic chk_got(input string name, input logic [31:0] e [$]);
    chk({name, "_len"}, 32'(got_q.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < got_q.size(); i++)
      chk(name, got_q[i], e[i]);
    got_q.delete();
  endtask

  vec_t vecs [18];

  initial begin
    logic [31:0] exp_q [$];
    int acc;
    int n;

    // load 0x1000
    vecs[0]  = mk(1,0,2,4'h0,32'h1000,0,       0,0,0,            1,0,0,            0,0,0,0,0,0);
    vecs[1]  = mk(0,0,0,0,0,0,                 0,0,0,            1,0,0,            0,0,0,0,0,0);
    vecs[2]  = mk(0,0,0,0,0,0,                 1,0,0,            1,0,0,            1,0,2,4'h0,32'h1000,0);
    vecs[3]  = mk(0,0,0,0,0,0,                 0,1,32'hDEADBEEF, 1,0,0,            0,0,0,0,0,0);
    vecs[4]  = mk(0,0,0,0,0,0,                 0,0,0,            1,1,32'hDEADBEEF, 0,0,0,0,0,0);
    vecs[5]  = mk(0,0,0,0,0,0,                 0,0,0,            1,0,0,            0,0,0,0,0,0);
    // store 0x12345678 to 0x2000; backend data must be discarded
    vecs[6]  = mk(1,1,2,4'hF,32'h2000,32'h12345678, 0,0,0,       1,0,0,            0,0,0,0,0,0);
    vecs[7]  = mk(0,0,0,0,0,0,                 0,0,0,            1,0,0,            0,0,0,0,0,0);
    vecs[8]  = mk(0,0,0,0,0,0,                 1,0,0,            1,0,0,            1,1,2,4'hF,32'h2000,32'h12345678);
    vecs[9]  = mk(0,0,0,0,0,0,                 0,1,32'hFFFFFFFF, 1,0,0,            0,0,0,0,0,0);
    vecs[10] = mk(0,0,0,0,0,0,                 0,0,0,            1,1,32'h0,        0,0,0,0,0,0);
    vecs[11] = mk(0,0,0,0,0,0,                 0,0,0,            1,0,0,            0,0,0,0,0,0);
    // illegal size 3 load goes out as a word
    vecs[12] = mk(1,0,3,4'h0,32'h1004,0,       0,0,0,            1,0,0,            0,0,0,0,0,0);
    vecs[13] = mk(0,0,0,0,0,0,                 0,0,0,            1,0,0,            0,0,0,0,0,0);
    vecs[14] = mk(0,0,0,0,0,0,                 1,0,0,            1,0,0,            1,0,2,4'h0,32'h1004,0);
    vecs[15] = mk(0,0,0,0,0,0,                 0,1,32'h0BADF00D, 1,0,0,            0,0,0,0,0,0);
    vecs[16] = mk(0,0,0,0,0,0,                 0,0,0,            1,1,32'h0BADF00D, 0,0,0,0,0,0);
    vecs[17] = mk(0,0,0,0,0,0,                 0,0,0,            1,0,0,            0,0,0,0,0,0);

    resetn = 1'b0;
    dcache_req = 0; dcache_wr = 0; dcache_size = 0; dcache_wstrb = 0;
    dcache_addr = 0; dcache_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
`ifdef DCACHE_RESP_ERR_EN
    mem_err = 0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("rst_addr_ok", 32'(dcache_addr_ok), 32'd1);
    chk("rst_data_ok", 32'(dcache_data_ok), 32'd0);
    chk("rst_rdata", dcache_rdata, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      dcache_req = vecs[i].req; dcache_wr = vecs[i].wr; dcache_size = vecs[i].size;
      dcache_wstrb = vecs[i].wstrb; dcache_addr = vecs[i].addr; dcache_wdata = vecs[i].wdata;
      mem_gnt = vecs[i].gnt; mem_rvalid = vecs[i].rvalid; mem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_addr_ok", i), 32'(dcache_addr_ok), 32'(vecs[i].e_addr_ok));
      chk($sformatf("v%0d_data_ok", i), 32'(dcache_data_ok), 32'(vecs[i].e_data_ok));
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].e_mem_req));
      if (vecs[i].e_data_ok)
        chk($sformatf("v%0d_rdata", i), dcache_rdata, vecs[i].e_rdata);
      if (vecs[i].e_mem_req) begin
        chk($sformatf("v%0d_mem_wr", i), 32'(mem_wr), 32'(vecs[i].e_mem_wr));
        chk($sformatf("v%0d_mem_size", i), 32'(mem_size), 32'(vecs[i].e_mem_size));
        chk($sformatf("v%0d_mem_wstrb", i), 32'(mem_wstrb), 32'(vecs[i].e_mem_wstrb));
        chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_mem_addr);
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
      end
    end
    dcache_req = 0; mem_gnt = 0; mem_rvalid = 0;

    // Fill: five back-to-back loads, first grant held off until cycle 8
    acc = 0;
    @(negedge clk);
    for (int c = 0; c < 16 && acc < 5; c++) begin
      dcache_req = 1'b1; dcache_wr = 1'b0; dcache_size = 2'd2; dcache_wstrb = 4'h0;
      dcache_addr = 32'h100 + 32'(4 * acc); dcache_wdata = 32'h0;
      mem_gnt = (c == 8); mem_rvalid = (c == 9); mem_rdata = 32'h11;
      #1;
      chk($sformatf("fill_c%0d_addr_ok", c), 32'(dcache_addr_ok), 32'((c < 4) || (c >= 11)));
      chk($sformatf("fill_c%0d_data_ok", c), 32'(dcache_data_ok), 32'(c == 10));
      if (c == 10) chk("fill_rdata", dcache_rdata, 32'h11);
      if (c >= 2 && c <= 8) chk($sformatf("fill_c%0d_mem_addr", c), mem_addr, 32'h100);
      if (c == 11) chk("fill_next_addr", mem_addr, 32'h104);
      if (dcache_addr_ok) acc++;
      @(negedge clk);
    end
    dcache_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("fill_accepts", 32'(acc), 32'd5);
    #1;
    chk("fill_full_again", 32'(dcache_addr_ok), 32'd0);
    serve(4, 40);
    exp_q = '{32'hBEEF0104, 32'hBEEF0108, 32'hBEEF010C, 32'hBEEF0110};
    chk_got("fill_drain", exp_q);

    // Backpressure: fields frozen for 10 cycles without grant
    push(1'b1, 2'd1, 4'h3, 32'h4000, 32'hCAFEF00D);
    n = 0;
    @(negedge clk); #1;
    while (!mem_req && n < 5) begin @(negedge clk); #1; n++; end
    for (int c = 0; c < 10; c++) begin
      chk("bp_mem_req", 32'(mem_req), 32'd1);
      chk("bp_mem_wr", 32'(mem_wr), 32'd1);
      chk("bp_mem_size", 32'(mem_size), 32'd1);
      chk("bp_mem_wstrb", 32'(mem_wstrb), 32'h3);
      chk("bp_mem_addr", mem_addr, 32'h4000);
      chk("bp_mem_wdata", mem_wdata, 32'hCAFEF00D);
      @(negedge clk); #1;
    end
    serve(1, 20);
    exp_q = '{32'h0};
    chk_got("bp_resp", exp_q);

    // Ordering: store then load to the same address, then four more (wraps)
    push(1'b1, 2'd2, 4'hF, 32'h3000, 32'h000000AA);
    push(1'b0, 2'd2, 4'h0, 32'h3000, 32'h0);
    serve(2, 30);
    exp_q = '{32'h0, 32'hAA};
    chk_got("order_a", exp_q);
    push(1'b1, 2'd0, 4'h1, 32'h3004, 32'h12345655);
    push(1'b0, 2'd2, 4'h0, 32'h3004, 32'h0);
    push(1'b1, 2'd1, 4'hC, 32'h3008, 32'h11223344);
    push(1'b0, 2'd2, 4'h0, 32'h3008, 32'h0);
    serve(4, 50);
    exp_q = '{32'h0, 32'hBEEF3055, 32'h0, 32'h11223008};
    chk_got("order_b", exp_q);

    // Reset while WAIT with three queued loads; a late rvalid must be ignored
    push(1'b0, 2'd2, 4'h0, 32'h5000, 32'h0);
    push(1'b0, 2'd2, 4'h0, 32'h5004, 32'h0);
    push(1'b0, 2'd2, 4'h0, 32'h5008, 32'h0);
    @(negedge clk);
    #1;
    chk("rst_pre_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_data_ok", 32'(dcache_data_ok), 32'd0);
    chk("midrst_addr_ok", 32'(dcache_addr_ok), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_rvalid = (i == 0); mem_rdata = 32'h99;
      #1;
      chk("postrst_data_ok", 32'(dcache_data_ok), 32'd0);
      chk("postrst_mem_req", 32'(mem_req), 32'd0);
    end
    mem_rvalid = 1'b0;

`ifdef DCACHE_RESP_ERR_EN
    push(1'b0, 2'd2, 4'h0, 32'h6000, 32'h0);
    n = 0;
    @(negedge clk); #1;
    while (!mem_req && n < 5) begin @(negedge clk); #1; n++; end
    chk("err_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_err = 1'b0;
    #1;
    chk("err_data_ok", 32'(dcache_data_ok), 32'd1);
    chk("err_flag", 32'(dcache_data_err), 32'd1);
    chk("err_rdata", dcache_rdata, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
